prog_seq_checker: RTL and testbench
===================================

Name: prog_seq_checker

Overview:
- Synthesizable successor to the single-program, three-phase Start/Ack bench flow.
- Launches NUM_PROGS programs on the processor in sequence through a Start/Ack handshake.
- After each Ack, sweeps a per-program data-memory window and compares it against a golden memory. Golden words flagged don't-care are skipped.
- Records per-program cycle count, mismatch count, first mismatch address, timeout and pass flags. Sits between TopLevel and a golden ROM in the FPGA/self-check build.

Parameters:
- NUM_PROGS, 3: programs run per sequence.
- ADDR_W, 8: data-memory address width.
- DATA_W, 8: data word width.
- CNT_W, 16: width of the cycle and error counters.
- TIMEOUT, 65535: maximum wait for Ack, in cycles. Must be ≤ 2^CNT_W-1.
- START_CYCLES, 1: number of cycles ProgStart is held high. Must be ≥ 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Go  in  1  single-cycle request to start a sequence. Sampled in IDLE and DONE only.
- WinLo  in  NUM_PROGS*ADDR_W  per-program inclusive window start. Slice p is at bits [p*ADDR_W +: ADDR_W].
- WinHi  in  NUM_PROGS*ADDR_W  per-program exclusive window end.
- ProgStart  out  1  Start signal to the DUT.
- ProgAck  in  1  Ack/done level from the DUT.
- MemAddr  out  ADDR_W  shared read address to the DUT data memory and the golden memory.
- DutData  in  DATA_W  DUT memory read data. Valid 1 cycle after MemAddr.
- GoldData  in  DATA_W  golden read data. Valid 1 cycle after MemAddr.
- GoldValid  in  1  golden word valid. 0 means don't-care. Same timing as GoldData.
- CurProg  out  $clog2(NUM_PROGS)  index of the program in progress.
- Busy  out  1  high from Go acceptance until DONE is entered.
- Done  out  1  level, high in DONE.
- Pass  out  NUM_PROGS  per program: no timeout and 0 mismatches.
- TimedOut  out  NUM_PROGS  per-program timeout flag.
- ErrCnt  out  NUM_PROGS*CNT_W  per-program mismatch count. Saturating.
- CycCnt  out  NUM_PROGS*CNT_W  per-program cycles from first ProgStart high to Ack accepted.
- FirstMis  out  NUM_PROGS*ADDR_W  per-program address of the first mismatch. 0 if none.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset asserted mid-sequence aborts immediately and drops ProgStart the same instant.
- IDLE: on Go, clear all result vectors, set p=0, go to START.
- START:
  - ProgStart=1 for exactly START_CYCLES cycles, then go to WAIT.
  - CycCnt[p] increments every cycle from the first START cycle.
- WAIT:
  - ProgStart=0.
  - "Armed" sets once ProgAck is sampled 0. A stale Ack left high from the previous program is therefore ignored.
  - Armed and ProgAck=1: go to SCAN with MemAddr=WinLo[p].
  - CycCnt[p] reaching TIMEOUT before that: set TimedOut[p], skip SCAN, go to NEXT.
- SCAN:
  - Issue one address per cycle, WinLo[p] up to WinHi[p]-1.
  - The compare stage is pipelined one cycle behind the address. A mismatch is GoldValid=1 and DutData≠GoldData.
  - On the first mismatch, latch FirstMis[p] from the delayed address. ErrCnt[p] saturates at 2^CNT_W-1.
  - After the last address, hold 1 drain cycle for the final compare, then go to NEXT.
  - If WinLo[p] ≥ WinHi[p]: empty window, zero compares, go straight to NEXT. ErrCnt stays 0.
  - The address counter never wraps. A window ending at 2^ADDR_W is expressed as WinHi=0 and is not supported; treat it as empty.
- NEXT:
  - Pass[p] = !TimedOut[p] && ErrCnt[p]==0.
  - If p==NUM_PROGS-1, go to DONE. Otherwise p++ and go to START.
- DONE:
  - Done=1, Busy=0, results held.
  - Go restarts the sequence: clear results, p=0, START on the next cycle. Go outside IDLE/DONE is ignored.
- Result outputs are stable except during the program slot that is currently writing them.

Decomposition:
- Package prog_chk_pkg holds:
  - state enum {IDLE, START, WAIT, SCAN, DRAIN, NEXT, DONE};
  - a saturating-increment function;
  - localparam PW = $clog2(NUM_PROGS).
- Sub-module mem_window_cmp contains:
  - the address counter;
  - the 1-stage compare pipeline;
  - the saturating error counter;
  - the first-mismatch latch.
  - Its interface is: start/lo/hi in, busy/err/first out.

Test Plan:
1. Reset, then Go. DUT model raises Ack 20 cycles after Start. Windows [30,60), [94,124), [192,195), golden equal to DUT → Pass=3'b111, ErrCnt all 0, CycCnt[0]=21, Done=1.
2. DUT[40]=0x5A, golden 0xA5 in P0's window → Pass[0]=0, ErrCnt[0]=1, FirstMis[0]=40, Pass[2:1]=2'b11.
3. Golden GoldValid=0 at 100 with a differing DUT word → no mismatch counted, Pass[1]=1.
4. P1 model never acks, TIMEOUT=50 → TimedOut=3'b010, CycCnt[1]=50, P2 still runs, Done=1.
5. Ack held high through P1's Start with stale level → no early SCAN. Scan begins only after Ack goes 0 then 1.
6. Reset_n low during SCAN of P1 → ProgStart=0, all outputs 0 asynchronously. Go after release runs a full clean sequence.
7. WinLo[2]=195, WinHi[2]=192 → zero reads, ErrCnt[2]=0, Pass[2]=1.

Source files
------------

// File: rtl/prog_chk_pkg.sv
// Shared types and helpers for the program-sequence checker.
package prog_chk_pkg;

    localparam int DEF_NUM_PROGS = 3;
    localparam int PW            = $clog2(DEF_NUM_PROGS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        SCAN  = 3'd3,
        DRAIN = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        if (value >= max_value) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/mem_window_cmp.sv
// Sweeps one address window [lo, hi) and compares DUT read data against golden data
// one cycle behind the issued address, counting mismatches and latching the first.
module mem_window_cmp
    import prog_chk_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [DATA_W-1:0] dut_data,
    input  logic [DATA_W-1:0] gold_data,
    input  logic              gold_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [CNT_W-1:0]  err,
    output logic [ADDR_W-1:0] first
);

    localparam logic [31:0]       ERR_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_d_r;
    logic [ADDR_W-1:0] first_r;
    logic [CNT_W-1:0]  err_r;
    logic              addr_active_r;
    logic              cmp_valid_r;
    logic              mismatch_s;

    // Read data arriving now belongs to addr_d_r; don't-care golden words never mismatch.
    always_comb begin
        mismatch_s = 1'b0;
        if (cmp_valid_r && gold_valid) begin
            mismatch_s = (dut_data != gold_data);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Address sweep, one-stage compare pipeline, saturating count and first-mismatch latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= {ADDR_W{1'b0}};
            addr_d_r      <= {ADDR_W{1'b0}};
            first_r       <= {ADDR_W{1'b0}};
            err_r         <= {CNT_W{1'b0}};
            addr_active_r <= 1'b0;
            cmp_valid_r   <= 1'b0;
        end else begin
            cmp_valid_r <= addr_active_r;
            addr_d_r    <= addr_r;
            if (start) begin
                addr_r        <= lo;
                addr_active_r <= (lo < hi);
                err_r         <= {CNT_W{1'b0}};
                first_r       <= {ADDR_W{1'b0}};
            end else begin
                // The counter stops on hi-1 so it can never wrap past the top of memory.
                if (addr_active_r) begin
                    if (addr_r == hi - ADDR_ONE) begin
                        addr_active_r <= 1'b0;
                    end else begin
                        addr_r <= addr_r + ADDR_ONE;
                    end
                end
                if (mismatch_s) begin
                    err_r <= CNT_W'(sat_inc(32'(err_r), ERR_MAX));
                    if (err_r == {CNT_W{1'b0}}) begin
                        first_r <= addr_d_r;
                    end
                end
            end
        end
    end

    assign addr  = addr_r;
    assign busy  = addr_active_r;
    assign err   = err_r;
    assign first = first_r;

endmodule

// File: rtl/prog_seq_checker.sv
// Runs NUM_PROGS programs through a Start/Ack handshake, then checks each program's
// data-memory window against golden memory and records per-program results.
module prog_seq_checker
    import prog_chk_pkg::*;
#(
    parameter int NUM_PROGS    = DEF_NUM_PROGS,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 65535,
    parameter int START_CYCLES = 1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Go,
    input  logic [NUM_PROGS*ADDR_W-1:0]   WinLo,
    input  logic [NUM_PROGS*ADDR_W-1:0]   WinHi,
    output logic                          ProgStart,
    input  logic                          ProgAck,
    output logic [ADDR_W-1:0]             MemAddr,
    input  logic [DATA_W-1:0]             DutData,
    input  logic [DATA_W-1:0]             GoldData,
    input  logic                          GoldValid,
    output logic [$clog2(NUM_PROGS)-1:0]  CurProg,
    output logic                          Busy,
    output logic                          Done,
    output logic [NUM_PROGS-1:0]          Pass,
    output logic [NUM_PROGS-1:0]          TimedOut,
    output logic [NUM_PROGS*CNT_W-1:0]    ErrCnt,
    output logic [NUM_PROGS*CNT_W-1:0]    CycCnt,
    output logic [NUM_PROGS*ADDR_W-1:0]   FirstMis
);

    localparam int                PROG_W     = (NUM_PROGS == DEF_NUM_PROGS) ? PW : $clog2(NUM_PROGS);
    localparam logic [PROG_W-1:0] PROG_LAST  = PROG_W'(NUM_PROGS - 1);
    localparam logic [PROG_W-1:0] PROG_ONE   = PROG_W'(1);
    localparam logic [31:0]       CNT_MAX    = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t              state_r;
    state_t              state_next_s;
    logic [PROG_W-1:0]   prog_r;
    logic                prog_start_r;
    logic                busy_r;
    logic                done_r;
    logic                armed_r;
    logic [CNT_W-1:0]    start_cnt_r;
    logic [CNT_W-1:0]    cyc_cnt_r   [NUM_PROGS];
    logic [CNT_W-1:0]    err_cnt_r   [NUM_PROGS];
    logic [ADDR_W-1:0]   first_mis_r [NUM_PROGS];
    logic [NUM_PROGS-1:0] timed_out_r;
    logic [NUM_PROGS-1:0] pass_r;

    logic                go_s;
    logic                accept_s;
    logic                timeout_s;
    logic [ADDR_W-1:0]   lo_s;
    logic [ADDR_W-1:0]   hi_s;
    logic [CNT_W-1:0]    cyc_inc_s;
    logic                cmp_busy_s;
    logic [CNT_W-1:0]    cmp_err_s;
    logic [ADDR_W-1:0]   cmp_first_s;

    mem_window_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .start      (accept_s),
        .lo         (lo_s),
        .hi         (hi_s),
        .dut_data   (DutData),
        .gold_data  (GoldData),
        .gold_valid (GoldValid),
        .addr       (MemAddr),
        .busy       (cmp_busy_s),
        .err        (cmp_err_s),
        .first      (cmp_first_s)
    );

    // Next-state decode plus handshake, timeout and window selection for the current program.
    always_comb begin
        state_next_s = state_r;
        go_s         = 1'b0;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        lo_s         = WinLo[int'(prog_r)*ADDR_W +: ADDR_W];
        hi_s         = WinHi[int'(prog_r)*ADDR_W +: ADDR_W];
        cyc_inc_s    = CNT_W'(sat_inc(32'(cyc_cnt_r[prog_r]), CNT_MAX));
        case (state_r)
            IDLE, DONE: begin
                if (Go) begin
                    go_s         = 1'b1;
                    state_next_s = START;
                end else begin
                    state_next_s = state_r;
                end
            end
            START: begin
                if (start_cnt_r == START_LAST) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = START;
                end
            end
            WAIT: begin
                // Ack only counts once it has been seen low, so a stale level is ignored.
                if (armed_r && ProgAck) begin
                    accept_s     = 1'b1;
                    state_next_s = SCAN;
                end else if (cyc_inc_s >= TIMEOUT_C) begin
                    timeout_s    = 1'b1;
                    state_next_s = NEXT;
                end else begin
                    state_next_s = WAIT;
                end
            end
            SCAN: begin
                if (cmp_busy_s) begin
                    state_next_s = SCAN;
                end else if (lo_s < hi_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = NEXT;
                end
            end
            DRAIN: begin
                state_next_s = NEXT;
            end
            NEXT: begin
                if (prog_r == PROG_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = START;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Sequencer state, handshake bookkeeping and per-program result registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= IDLE;
            prog_r       <= {PROG_W{1'b0}};
            prog_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            armed_r      <= 1'b0;
            start_cnt_r  <= {CNT_W{1'b0}};
            timed_out_r  <= {NUM_PROGS{1'b0}};
            pass_r       <= {NUM_PROGS{1'b0}};
            for (int p = 0; p < NUM_PROGS; p++) begin
                cyc_cnt_r[p]   <= {CNT_W{1'b0}};
                err_cnt_r[p]   <= {CNT_W{1'b0}};
                first_mis_r[p] <= {ADDR_W{1'b0}};
            end
        end else begin
            state_r      <= state_next_s;
            prog_start_r <= (state_next_s == START);
            if (go_s) begin
                prog_r      <= {PROG_W{1'b0}};
                busy_r      <= 1'b1;
                done_r      <= 1'b0;
                armed_r     <= 1'b0;
                start_cnt_r <= {CNT_W{1'b0}};
                timed_out_r <= {NUM_PROGS{1'b0}};
                pass_r      <= {NUM_PROGS{1'b0}};
                for (int p = 0; p < NUM_PROGS; p++) begin
                    cyc_cnt_r[p]   <= {CNT_W{1'b0}};
                    err_cnt_r[p]   <= {CNT_W{1'b0}};
                    first_mis_r[p] <= {ADDR_W{1'b0}};
                end
            end
            if (state_r == START || state_r == WAIT) begin
                cyc_cnt_r[prog_r] <= cyc_inc_s;
            end
            if (state_r == START) begin
                start_cnt_r <= start_cnt_r + CNT_ONE;
            end
            if (state_r == WAIT && !ProgAck) begin
                armed_r <= 1'b1;
            end
            if (timeout_s) begin
                timed_out_r[prog_r] <= 1'b1;
            end
            // A timed-out program was never scanned, so its error fields stay cleared.
            if (state_r == NEXT) begin
                pass_r[prog_r] <= !timed_out_r[prog_r] && (cmp_err_s == {CNT_W{1'b0}});
                if (!timed_out_r[prog_r]) begin
                    err_cnt_r[prog_r]   <= cmp_err_s;
                    first_mis_r[prog_r] <= cmp_first_s;
                end
                if (prog_r == PROG_LAST) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    prog_r      <= prog_r + PROG_ONE;
                    start_cnt_r <= {CNT_W{1'b0}};
                    armed_r     <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PROGS; p++) begin : g_out
        assign CycCnt[p*CNT_W +: CNT_W]     = cyc_cnt_r[p];
        assign ErrCnt[p*CNT_W +: CNT_W]     = err_cnt_r[p];
        assign FirstMis[p*ADDR_W +: ADDR_W] = first_mis_r[p];
    end

    assign ProgStart = prog_start_r;
    assign CurProg   = prog_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Pass      = pass_r;
    assign TimedOut  = timed_out_r;

endmodule

// File: tb/tb_prog_seq_checker.sv
// Directed bench for prog_seq_checker with a behavioural Ack model and synchronous memories.
module tb_prog_seq_checker;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Go = 1'b0;
    logic [23:0] WinLo;
    logic [23:0] WinHi;
    logic        ProgStart;
    logic        ProgAck = 1'b0;
    logic [7:0]  MemAddr;
    logic [7:0]  DutData = 8'd0;
    logic [7:0]  GoldData = 8'd0;
    logic        GoldValid = 1'b0;
    logic [1:0]  CurProg;
    logic        Busy;
    logic        Done;
    logic [2:0]  Pass;
    logic [2:0]  TimedOut;
    logic [47:0] ErrCnt;
    logic [47:0] CycCnt;
    logic [23:0] FirstMis;

    int checks = 0;
    int failures = 0;

    logic [7:0] dut_mem  [256];
    logic [7:0] gold_mem [256];
    logic       gold_vld [256];

    int  drop_at   [3];
    int  rise_at   [3];
    bit  never_ack [3];
    int  ack_cnt = 0;
    logic ps_q = 1'b0;

    prog_seq_checker #(
        .NUM_PROGS    (3),
        .ADDR_W       (8),
        .DATA_W       (8),
        .CNT_W        (16),
        .TIMEOUT      (50),
        .START_CYCLES (1)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Go        (Go),
        .WinLo     (WinLo),
        .WinHi     (WinHi),
        .ProgStart (ProgStart),
        .ProgAck   (ProgAck),
        .MemAddr   (MemAddr),
        .DutData   (DutData),
        .GoldData  (GoldData),
        .GoldValid (GoldValid),
        .CurProg   (CurProg),
        .Busy      (Busy),
        .Done      (Done),
        .Pass      (Pass),
        .TimedOut  (TimedOut),
        .ErrCnt    (ErrCnt),
        .CycCnt    (CycCnt),
        .FirstMis  (FirstMis)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read memories: data for MemAddr appears one cycle later.
    always @(posedge Clk) begin
        DutData   <= dut_mem[MemAddr];
        GoldData  <= gold_mem[MemAddr];
        GoldValid <= gold_vld[MemAddr];
    end

    // Processor model: Ack level rises rise_at cycles after Start edge, drops at drop_at.
    always @(posedge Clk) begin
        ps_q <= ProgStart;
        if (ProgStart && !ps_q) begin
            ack_cnt <= 1;
            if (drop_at[CurProg] == 0) ProgAck <= 1'b0;
        end else if (ack_cnt != 0) begin
            ack_cnt <= ack_cnt + 1;
            if (ack_cnt == drop_at[CurProg]) ProgAck <= 1'b0;
            if (ack_cnt == rise_at[CurProg] && !never_ack[CurProg]) ProgAck <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input string tag);
        bit seen;
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check({tag, "_done_wait"}, 64'(seen), 64'd1);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin
            dut_mem[i]  = 8'(i * 3 + 1);
            gold_mem[i] = 8'(i * 3 + 1);
            gold_vld[i] = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int p = 0; p < 3; p++) begin
            drop_at[p]   = 0;
            rise_at[p]   = 19;
            never_ack[p] = 1'b0;
        end
        init_mem();
        WinLo = {8'd192, 8'd94, 8'd30};
        WinHi = {8'd195, 8'd124, 8'd60};

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_progstart", 64'(ProgStart), 64'd0);
        check("rst_busy_done", 64'({Busy, Done}), 64'd0);
        check("rst_results", 64'({Pass, TimedOut, ErrCnt}), 64'd0);
        check("rst_cyccnt", 64'(CycCnt), 64'd0);
        check("rst_addr_prog", 64'({MemAddr, CurProg, FirstMis}), 64'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // 1: all programs match
        run_seq("t1");
        check("t1_pass", 64'(Pass), 64'd7);
        check("t1_errcnt", 64'(ErrCnt), 64'd0);
        check("t1_cyc0", 64'(CycCnt[15:0]), 64'd21);
        check("t1_cyc1", 64'(CycCnt[31:16]), 64'd21);
        check("t1_cyc2", 64'(CycCnt[47:32]), 64'd21);
        check("t1_timedout", 64'(TimedOut), 64'd0);
        check("t1_done_busy", 64'({Done, Busy}), 64'd2);
        check("t1_firstmis", 64'(FirstMis), 64'd0);

        // 2: single mismatch in P0
        dut_mem[40] = 8'h5A;
        gold_mem[40] = 8'hA5;
        run_seq("t2");
        check("t2_pass", 64'(Pass), 64'd6);
        check("t2_err0", 64'(ErrCnt[15:0]), 64'd1);
        check("t2_first0", 64'(FirstMis[7:0]), 64'd40);
        check("t2_err12", 64'(ErrCnt[47:16]), 64'd0);

        // 2b: window edges -- first and last inside count, neighbours outside do not
        dut_mem[29] = 8'hFF;
        dut_mem[30] = 8'hFF;
        dut_mem[59] = 8'hFF;
        dut_mem[60] = 8'hFF;
        run_seq("t2b");
        check("t2b_err0", 64'(ErrCnt[15:0]), 64'd3);
        check("t2b_first0", 64'(FirstMis[7:0]), 64'd30);
        check("t2b_pass", 64'(Pass), 64'd6);
        init_mem();

        // 3: don't-care golden word with differing DUT data
        dut_mem[100] = 8'h00;
        gold_mem[100] = 8'h77;
        gold_vld[100] = 1'b0;
        run_seq("t3");
        check("t3_pass", 64'(Pass), 64'd7);
        check("t3_err1", 64'(ErrCnt[31:16]), 64'd0);
        init_mem();

        // 4: P1 never acks
        never_ack[1] = 1'b1;
        run_seq("t4");
        check("t4_timedout", 64'(TimedOut), 64'd2);
        check("t4_cyc1", 64'(CycCnt[31:16]), 64'd50);
        check("t4_pass", 64'(Pass), 64'd5);
        check("t4_cyc2", 64'(CycCnt[47:32]), 64'd21);
        check("t4_err_first1", 64'({ErrCnt[31:16], FirstMis[15:8]}), 64'd0);
        never_ack[1] = 1'b0;

        // 5: stale Ack held high through P1 start, drops, then rises
        run_seq("t5pre");
        drop_at[1] = 5;
        run_seq("t5");
        check("t5_cyc1", 64'(CycCnt[31:16]), 64'd21);
        check("t5_pass", 64'(Pass), 64'd7);
        drop_at[1] = 0;

        // 7: inverted P2 window, with a real mismatch left in P1
        WinLo = {8'd195, 8'd94, 8'd30};
        WinHi = {8'd192, 8'd124, 8'd60};
        dut_mem[100] = 8'h00;
        dut_mem[192] = 8'hEE;
        dut_mem[193] = 8'hEE;
        dut_mem[194] = 8'hEE;
        run_seq("t7");
        check("t7_err1", 64'(ErrCnt[31:16]), 64'd1);
        check("t7_first1", 64'(FirstMis[15:8]), 64'd100);
        check("t7_err2", 64'(ErrCnt[47:32]), 64'd0);
        check("t7_pass", 64'(Pass), 64'd5);
        check("t7_first2", 64'(FirstMis[23:16]), 64'd0);
        init_mem();
        WinLo = {8'd192, 8'd94, 8'd30};
        WinHi = {8'd195, 8'd124, 8'd60};

        // 6: reset during P1 scan
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (CurProg == 2'd1 && MemAddr == 8'd100) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check("t6_scan_wait", 64'(seen), 64'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 64'({ProgStart, Busy, Done, CurProg}), 64'd0);
        check("t6_rst_cyc", 64'(CycCnt), 64'd0);
        check("t6_rst_res", 64'({Pass, TimedOut, ErrCnt, MemAddr}), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // 6b: reset while ProgStart is high drops it immediately
        @(negedge Clk);
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        check("t6b_progstart_hi", 64'(ProgStart), 64'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t6b_progstart_lo", 64'(ProgStart), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Clean sequence after the aborts
        run_seq("t6c");
        check("t6c_pass", 64'(Pass), 64'd7);
        check("t6c_cyc0", 64'(CycCnt[15:0]), 64'd21);
        check("t6c_err", 64'({ErrCnt, TimedOut}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
